sr_shift_out: RTL and testbench

- Serial shift-out engine at the far end of the controller's load/busy/latch handshake.
- Accepts one parallel word per i_load and clocks it out MSB- or LSB-first on o_sdata/o_sclk.
- Generates the storage-register strobe o_rclk for a 74HC595-style chain when i_latch is requested.
- Reports o_busy so the upstream controller can pace word loads.

---
 rtl/sr_shift_out.sv | 153 +++++++++++++++
 tb/tb_sr_shift_out.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/sr_shift_out.sv
// Serial shift-out engine for a 74HC595-style chain. The first bit appears on the load edge and the word finishes 2*CLK_DIV*DATA_W+1 cycles later.
// o_busy is high while shifting or while a deferred latch pulse runs; i_load is ignored while busy.
module sr_shift_out #(
  parameter int DATA_W    = 8,
  parameter int CLK_DIV   = 2,
  parameter int MSB_FIRST = 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_load,
  input  logic              i_latch,
  output logic              o_busy,
  output logic              o_sdata,
  output logic              o_sclk,
  output logic              o_rclk
);

  localparam int CNT_W = $clog2(DATA_W) + 1;
  localparam int DIV_W = $clog2(CLK_DIV) + 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);
  localparam logic [DIV_W-1:0] DIV_END  = DIV_W'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOW,
    ST_HIGH,
    ST_END,
    ST_LATCH
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] shreg;
  logic [CNT_W-1:0]  bit_cnt;
  logic [DIV_W-1:0]  div;
  logic [DIV_W-1:0]  rclk_cnt;
  logic              latch_pend;
  logic              rclk_idle;

  // A new request merges into any pulse that is already running.
  logic latch_req;
  assign latch_req = i_latch && !rclk_idle;

  logic first_bit;
  logic next_bit;
  logic [DATA_W-1:0] shreg_nxt;
  assign first_bit = (MSB_FIRST != 0) ? i_data[DATA_W-1] : i_data[0];
  assign next_bit  = (MSB_FIRST != 0) ? shreg[DATA_W-2]  : shreg[1];
  assign shreg_nxt = (MSB_FIRST != 0) ? {shreg[DATA_W-2:0], 1'b0}
                                      : {1'b0, shreg[DATA_W-1:1]};

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= ST_IDLE;
      shreg      <= '0;
      bit_cnt    <= '0;
      div        <= '0;
      rclk_cnt   <= '0;
      latch_pend <= 1'b0;
      rclk_idle  <= 1'b0;
      o_busy     <= 1'b0;
      o_sdata    <= 1'b0;
      o_sclk     <= 1'b0;
      o_rclk     <= 1'b0;
    end else begin
      // Idle-issued rclk pulse runs on its own counter so a load may overlap it.
      if (rclk_idle) begin
        if (rclk_cnt == DIV_END) begin
          rclk_idle <= 1'b0;
          rclk_cnt  <= '0;
          o_rclk    <= 1'b0;
        end else begin
          rclk_cnt <= rclk_cnt + DIV_W'(1);
        end
      end

      case (state)
        ST_IDLE: begin
          o_sclk <= 1'b0;
          if (i_load) begin
            shreg   <= i_data;
            o_sdata <= first_bit;
            o_busy  <= 1'b1;
            bit_cnt <= '0;
            div     <= '0;
            state   <= ST_LOW;
            if (latch_req) latch_pend <= 1'b1;
          end else if (latch_req) begin
            o_rclk    <= 1'b1;
            rclk_idle <= 1'b1;
            rclk_cnt  <= '0;
          end
        end

        ST_LOW: begin
          if (latch_req) latch_pend <= 1'b1;
          if (div == DIV_END) begin
            o_sclk <= 1'b1;
            div    <= '0;
            state  <= ST_HIGH;
          end else begin
            div <= div + DIV_W'(1);
          end
        end

        ST_HIGH: begin
          if (latch_req) latch_pend <= 1'b1;
          if (div == DIV_END) begin
            o_sclk <= 1'b0;
            div    <= '0;
            if (bit_cnt == LAST_BIT) begin
              state <= ST_END;
            end else begin
              shreg   <= shreg_nxt;
              o_sdata <= next_bit;
              bit_cnt <= bit_cnt + CNT_W'(1);
              state   <= ST_LOW;
            end
          end else begin
            div <= div + DIV_W'(1);
          end
        end

        ST_END: begin
          if (latch_pend || latch_req) begin
            latch_pend <= 1'b1;
            o_rclk     <= 1'b1;
            div        <= '0;
            state      <= ST_LATCH;
          end else begin
            o_busy <= 1'b0;
            state  <= ST_IDLE;
          end
        end

        ST_LATCH: begin
          if (div == DIV_END) begin
            o_rclk     <= 1'b0;
            o_busy     <= 1'b0;
            latch_pend <= 1'b0;
            div        <= '0;
            state      <= ST_IDLE;
          end else begin
            div <= div + DIV_W'(1);
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sr_shift_out.sv
// Bench for sr_shift_out: an MSB-first and an LSB-first instance share one stimulus stream.
// Outputs are sampled on the falling clock edge and inputs are driven right after sampling.
module tb_sr_shift_out;

  logic       clk;
  logic       rst;
  logic [7:0] data;
  logic       load;
  logic       latch;
  logic [1:0] busy_o, sdata_o, sclk_o, rclk_o;

  int checks   = 0;
  int failures = 0;

  sr_shift_out #(.DATA_W(8), .CLK_DIV(2), .MSB_FIRST(1)) dut_m (
    .i_clk(clk), .i_rst(rst), .i_data(data), .i_load(load), .i_latch(latch),
    .o_busy(busy_o[0]), .o_sdata(sdata_o[0]), .o_sclk(sclk_o[0]), .o_rclk(rclk_o[0])
  );

  sr_shift_out #(.DATA_W(8), .CLK_DIV(2), .MSB_FIRST(0)) dut_l (
    .i_clk(clk), .i_rst(rst), .i_data(data), .i_load(load), .i_latch(latch),
    .o_busy(busy_o[1]), .o_sdata(sdata_o[1]), .o_sclk(sclk_o[1]), .o_rclk(rclk_o[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input int dut, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s dut=%0d actual=%0d required=%0d", name, dut, act, exp);
    end
  endtask

  // seq_*: sampled bits, first sampled bit in bit 7. Cycle 0 is the cycle i_load is driven.
  typedef struct {
    logic [7:0] data;
    int         latch_at;
    int         load2_at;
    logic [7:0] load2_data;
    logic [7:0] seq_m;
    logic [7:0] seq_l;
    int         busy_cycles;
    int         busy_fall;
    int         rclk_start;
    int         rclk_len;
  } vec_t;

  vec_t vecs[5];

  task automatic run_vec(input vec_t v);
    logic [7:0] seq[2];
    int nb[2], bcnt[2], bfall[2], rstart[2], rlen[2], viol[2], lastfall[2];
    logic psclk[2], psdata[2], pbusy[2];
    for (int d = 0; d < 2; d++) begin
      seq[d] = '0; nb[d] = 0; bcnt[d] = 0; bfall[d] = -1;
      rstart[d] = -1; rlen[d] = 0; viol[d] = 0; lastfall[d] = -1;
      psclk[d] = 1'b0; psdata[d] = 1'b0; pbusy[d] = 1'b0;
    end
    for (int c = 0; c < 45; c++) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (c > 0) begin
          if (sclk_o[d] && !psclk[d]) begin
            seq[d] = {seq[d][6:0], sdata_o[d]};
            nb[d]++;
          end
          if (!sclk_o[d] && psclk[d]) lastfall[d] = c;
          if (psclk[d] && sclk_o[d] && (sdata_o[d] != psdata[d])) viol[d]++;
          if (pbusy[d] && !busy_o[d] && bfall[d] < 0) bfall[d] = c;
        end
        if (busy_o[d]) bcnt[d]++;
        if (rclk_o[d]) begin
          if (rstart[d] < 0) rstart[d] = c;
          rlen[d]++;
        end
        psclk[d] = sclk_o[d];
        psdata[d] = sdata_o[d];
        pbusy[d] = busy_o[d];
      end
      load  = (c == 0) || (c == v.load2_at);
      data  = (c == 0) ? v.data : v.load2_data;
      latch = (c == v.latch_at);
    end
    for (int d = 0; d < 2; d++) begin
      chk("bit_sequence", d, int'(seq[d]), int'((d == 0) ? v.seq_m : v.seq_l));
      chk("sclk_rises", d, nb[d], 8);
      chk("busy_cycles", d, bcnt[d], v.busy_cycles);
      chk("busy_fall_cycle", d, bfall[d], v.busy_fall);
      chk("sdata_change_while_sclk_high", d, viol[d], 0);
      chk("rclk_len", d, rlen[d], v.rclk_len);
      chk("rclk_start", d, rstart[d], v.rclk_start);
      if (v.rclk_len > 0) begin
        chk("rclk_after_last_sclk_fall", d, int'(rstart[d] > lastfall[d]), 1);
        chk("busy_falls_with_rclk", d, bfall[d], rstart[d] + rlen[d]);
      end
    end
  endtask

  initial begin
    vecs[0] = '{8'hA5, -1, -1, 8'h00, 8'hA5, 8'hA5, 33, 34, -1, 0};
    vecs[1] = '{8'h01, -1, -1, 8'h00, 8'h01, 8'h80, 33, 34, -1, 0};
    vecs[2] = '{8'hFF, -1,  5, 8'h00, 8'hFF, 8'hFF, 33, 34, -1, 0};
    vecs[3] = '{8'h3C, 10, -1, 8'h00, 8'h3C, 8'h3C, 35, 36, 34, 2};
    vecs[4] = '{8'h12, -1, -1, 8'h00, 8'h12, 8'h48, 33, 34, -1, 0};

    // Reset held with load asserted: everything stays 0.
    rst = 1'b1; load = 1'b1; latch = 1'b0; data = 8'h55;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        chk("reset_busy", d, int'(busy_o[d]), 0);
        chk("reset_sdata", d, int'(sdata_o[d]), 0);
        chk("reset_sclk", d, int'(sclk_o[d]), 0);
        chk("reset_rclk", d, int'(rclk_o[d]), 0);
      end
    end
    rst = 1'b0;
    @(negedge clk);
    chk("first_load_busy", 0, int'(busy_o[0]), 1);
    chk("first_load_busy", 1, int'(busy_o[1]), 1);
    chk("first_load_sdata", 0, int'(sdata_o[0]), 0);
    chk("first_load_sdata", 1, int'(sdata_o[1]), 1);
    load = 1'b0;
    repeat (40) @(negedge clk);
    chk("first_load_done", 0, int'(busy_o[0]), 0);
    chk("first_load_done", 1, int'(busy_o[1]), 0);

    for (int i = 0; i < 5; i++) begin
      run_vec(vecs[i]);
      repeat (2) @(negedge clk);
    end

    // Idle latch, load one cycle later, then reset mid-shift.
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        case (c)
          1: begin
            chk("idle_rclk_c1", d, int'(rclk_o[d]), 1);
            chk("idle_rclk_no_busy_c1", d, int'(busy_o[d]), 0);
          end
          2: begin
            chk("idle_rclk_c2", d, int'(rclk_o[d]), 1);
            chk("load_busy_c2", d, int'(busy_o[d]), 1);
            chk("load_sdata_c2", d, int'(sdata_o[d]), 1);
          end
          3: begin
            chk("idle_rclk_c3", d, int'(rclk_o[d]), 0);
            chk("sclk_low_c3", d, int'(sclk_o[d]), 0);
          end
          4: chk("sclk_rise_c4", d, int'(sclk_o[d]), 1);
          13: begin
            chk("abort_sclk", d, int'(sclk_o[d]), 0);
            chk("abort_busy", d, int'(busy_o[d]), 0);
            chk("abort_sdata", d, int'(sdata_o[d]), 0);
            chk("abort_rclk", d, int'(rclk_o[d]), 0);
          end
          default: ;
        endcase
      end
      latch = (c == 0);
      load  = (c == 1);
      data  = 8'h81;
      rst   = (c == 12);
    end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("post_abort_idle_sclk", 0, int'(sclk_o[0]), 0);
    chk("post_abort_idle_busy", 1, int'(busy_o[1]), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
